// File: rtl/score_keeper.sv
// Multi-player rally score keeper: synchronised point inputs, saturating
// per-player scores, win-by-margin detection and a timed freeze after each point.
module score_keeper #(
  parameter int NUM_PLAYERS = 2,
  parameter int SCORE_W     = 4,
  parameter int WIN_SCORE   = 9,
  parameter int WIN_BY      = 1,
  parameter int HOLD_CYCLES = 50000000
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_PLAYERS-1:0]         point_in,
  input  logic                           new_game,
  output logic [NUM_PLAYERS*SCORE_W-1:0] score,
  output logic                           done,
  output logic                           match_over,
  output logic [NUM_PLAYERS-1:0]         winner,
  output logic [1:0]                     serve
);

  localparam int                 CNT_W       = $clog2(HOLD_CYCLES) + 1;
  localparam logic [SCORE_W-1:0] SCORE_MAX   = {SCORE_W{1'b1}};
  localparam logic [SCORE_W-1:0] WIN_SCORE_V = SCORE_W'(WIN_SCORE);
  localparam logic [SCORE_W+1:0] WIN_BY_V    = (SCORE_W+2)'(WIN_BY);
  localparam logic [CNT_W-1:0]   HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    PLAY       = 2'd0,
    POINT_HOLD = 2'd1,
    MATCH_OVER = 2'd2
  } state_t;

  state_t                 state, state_next;
  logic [NUM_PLAYERS-1:0] sync1, sync2, edge_q, pt_event;
  logic [SCORE_W-1:0]     score_q [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0] winner_q, scorer_oh;
  logic [1:0]             serve_q, scorer;
  logic [CNT_W-1:0]       hold_cnt;
  logic                   hit, accept, win;
  logic [SCORE_W-1:0]     cur_val, new_val, max_other;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1  <= '0;
      sync2  <= '0;
      edge_q <= '0;
    end else begin
      sync1  <= point_in;
      sync2  <= sync1;
      edge_q <= sync2;
    end
  end

  assign pt_event = sync2 & ~edge_q;

  // NOTE: every always_comb output gets a default first so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    hit       = 1'b0;
    scorer    = 2'd0;
    cur_val   = '0;
    max_other = '0;
    // Descending scan so the lowest-indexed simultaneous scorer wins.
    for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
      if (pt_event[i]) begin
        hit    = 1'b1;
        scorer = 2'(i);
      end
    end
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (2'(i) == scorer)             cur_val   = score_q[i];
      else if (score_q[i] > max_other) max_other = score_q[i];
    end
    scorer_oh = NUM_PLAYERS'(1) << scorer;
    new_val   = (cur_val == SCORE_MAX) ? SCORE_MAX : cur_val + SCORE_W'(1);
    win       = ((new_val >= WIN_SCORE_V) &&
                 ({2'b00, new_val} >= {2'b00, max_other} + WIN_BY_V)) ||
                (new_val == SCORE_MAX);
    accept    = hit && (state == PLAY) && !new_game;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= PLAY;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      PLAY:       if (accept) state_next = win ? MATCH_OVER : POINT_HOLD;
      POINT_HOLD: if (hold_cnt == HOLD_LAST) state_next = PLAY;
      MATCH_OVER: state_next = MATCH_OVER;
      default:    state_next = PLAY;
    endcase
    if (new_game) state_next = PLAY;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_cnt <= '0;
    end else if ((state == POINT_HOLD) && (state_next == POINT_HOLD)) begin
      hold_cnt <= hold_cnt + CNT_W'(1);
    end else begin
      hold_cnt <= '0;
    end
  end

  // NOTE: the score array is a handful of flops, not a RAM, so it is reset
  // explicitly like any other state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_PLAYERS; i++) score_q[i] <= '0;
      winner_q <= '0;
      serve_q  <= 2'd0;
    end else if (new_game) begin
      for (int i = 0; i < NUM_PLAYERS; i++) score_q[i] <= '0;
      winner_q <= '0;
      serve_q  <= 2'd0;
    end else if (accept) begin
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        if (2'(i) == scorer) score_q[i] <= new_val;
      end
      serve_q <= (scorer == 2'd0) ? 2'd1 : 2'd0;
      if (win) winner_q <= scorer_oh;
    end
  end

  always_comb begin
    score = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) score[i*SCORE_W +: SCORE_W] = score_q[i];
    done       = (state != PLAY);
    match_over = (state == MATCH_OVER);
    winner     = winner_q;
    serve      = serve_q;
  end

endmodule

// File: tb/tb_score_keeper.sv
// Scoreboard bench for score_keeper: two instances (short match and saturating
// match); stimulus pushes expected snapshots, one monitor pops and compares.
module tb_score_keeper;

  typedef struct packed {
    logic [7:0] score;
    logic [1:0] serve;
    logic       done;
    logic       mo;
    logic [1:0] winner;
  } snap_t;

  typedef struct {
    string name;
    snap_t s;
  } ent_t;

  logic       clk = 1'b0;
  logic       rst_a, rst_b, ng_a, ng_b;
  logic [1:0] pt_a, pt_b;
  logic [7:0] score_a, score_b;
  logic       done_a, done_b, mo_a, mo_b;
  logic [1:0] winner_a, winner_b, serve_a, serve_b;

  ent_t evq_a[$], evq_b[$], prq_a[$], prq_b[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;
  logic prev_a = 1'b0;
  logic prev_b = 1'b0;
  logic fin_req = 1'b0;
  logic fin_done = 1'b0;
  ent_t e;

  always #5 clk = ~clk;

  score_keeper #(.NUM_PLAYERS(2), .SCORE_W(4), .WIN_SCORE(3), .WIN_BY(2), .HOLD_CYCLES(4)) dut_a (
    .clk(clk), .rst(rst_a), .point_in(pt_a), .new_game(ng_a), .score(score_a),
    .done(done_a), .match_over(mo_a), .winner(winner_a), .serve(serve_a));

  score_keeper #(.NUM_PLAYERS(2), .SCORE_W(4), .WIN_SCORE(15), .WIN_BY(2), .HOLD_CYCLES(4)) dut_b (
    .clk(clk), .rst(rst_b), .point_in(pt_b), .new_game(ng_b), .score(score_b),
    .done(done_b), .match_over(mo_b), .winner(winner_b), .serve(serve_b));

  function automatic snap_t mk(logic [7:0] s, logic [1:0] sv, logic d, logic m, logic [1:0] w);
    snap_t r;
    r.score = s; r.serve = sv; r.done = d; r.mo = m; r.winner = w;
    return r;
  endfunction

  task automatic check(input string name, input snap_t act, input snap_t exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got score=%h serve=%0d done=%b match_over=%b winner=%b, expected score=%h serve=%0d done=%b match_over=%b winner=%b",
                  name, act.score, act.serve, act.done, act.mo, act.winner,
                  exp.score, exp.serve, exp.done, exp.mo, exp.winner);
  endtask

  task automatic check_num(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Monitor: a rising done is the DUT presenting a scored point; probes are
  // explicit snapshot requests from the stimulus side.
  always @(negedge clk) begin
    if (done_a && !prev_a) begin
      if (evq_a.size() == 0) check_num("a_unexpected_point", 1, 0);
      else begin
        e = evq_a.pop_front();
        check(e.name, '{score_a, serve_a, done_a, mo_a, winner_a}, e.s);
      end
    end
    if (done_b && !prev_b) begin
      if (evq_b.size() == 0) check_num("b_unexpected_point", 1, 0);
      else begin
        e = evq_b.pop_front();
        check(e.name, '{score_b, serve_b, done_b, mo_b, winner_b}, e.s);
      end
    end
    while (prq_a.size() > 0) begin
      e = prq_a.pop_front();
      check(e.name, '{score_a, serve_a, done_a, mo_a, winner_a}, e.s);
    end
    while (prq_b.size() > 0) begin
      e = prq_b.pop_front();
      check(e.name, '{score_b, serve_b, done_b, mo_b, winner_b}, e.s);
    end
    prev_a = done_a;
    prev_b = done_b;
    if (fin_req && !fin_done) begin
      check_num("a_missing_points", evq_a.size(), 0);
      check_num("b_missing_points", evq_b.size(), 0);
      fin_done = 1'b1;
    end
  end

  task automatic expect_pt(input bit b, input string n, input snap_t s);
    ent_t x;
    x.name = n; x.s = s;
    if (b) evq_b.push_back(x); else evq_a.push_back(x);
  endtask

  task automatic probe(input bit b, input string n, input snap_t s);
    ent_t x;
    x.name = n; x.s = s;
    if (b) prq_b.push_back(x); else prq_a.push_back(x);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Starts and ends at posedge+1; on return the point (if accepted) is registered.
  task automatic pulse(input bit b, input logic [1:0] m, input bit with_ng);
    if (b) pt_b = m; else pt_a = m;
    idle(1);
    if (b) pt_b = 2'b00; else pt_a = 2'b00;
    idle(1);
    if (with_ng) begin
      if (b) ng_b = 1'b1; else ng_a = 1'b1;
    end
    idle(1);
    ng_a = 1'b0;
    ng_b = 1'b0;
  endtask

  initial begin
    rst_a = 1'b0; rst_b = 1'b0; ng_a = 1'b0; ng_b = 1'b0;
    pt_a = 2'b00; pt_b = 2'b00;
    #1;
    probe(0, "a_reset", mk(8'h00, 2'd0, 0, 0, 2'b00));
    probe(1, "b_reset", mk(8'h00, 2'd0, 0, 0, 2'b00));
    idle(2);
    rst_a = 1'b1; rst_b = 1'b1;
    idle(2);

    // Single point and freeze length
    expect_pt(0, "a_single_point", mk(8'h01, 2'd1, 1, 0, 2'b00));
    pulse(0, 2'b01, 0);
    idle(3);
    probe(0, "a_hold_last_cycle", mk(8'h01, 2'd1, 1, 0, 2'b00));
    idle(1);
    probe(0, "a_hold_released", mk(8'h01, 2'd1, 0, 0, 2'b00));

    expect_pt(0, "a_p1_point", mk(8'h11, 2'd0, 1, 0, 2'b00));
    pulse(0, 2'b10, 0);
    idle(4);
    // Second P1 pulse lands inside the freeze and must be ignored
    expect_pt(0, "a_p1_again", mk(8'h21, 2'd0, 1, 0, 2'b00));
    pulse(0, 2'b10, 0);
    pulse(0, 2'b10, 0);
    idle(1);
    probe(0, "a_discard_in_hold", mk(8'h21, 2'd0, 0, 0, 2'b00));

    // Deuce: 2:2 -> 3:2 no win -> 4:2 win by two
    expect_pt(0, "a_deuce_2_2", mk(8'h22, 2'd1, 1, 0, 2'b00));
    pulse(0, 2'b01, 0);
    idle(4);
    expect_pt(0, "a_3_2_no_win", mk(8'h23, 2'd1, 1, 0, 2'b00));
    pulse(0, 2'b01, 0);
    idle(4);
    expect_pt(0, "a_4_2_win", mk(8'h24, 2'd1, 1, 1, 2'b01));
    pulse(0, 2'b01, 0);
    idle(2);
    pulse(0, 2'b10, 0);
    idle(6);
    probe(0, "a_discard_in_match_over", mk(8'h24, 2'd1, 1, 1, 2'b01));
    idle(1);

    // Asynchronous reset in MATCH_OVER: sampled before the next clock edge
    rst_a = 1'b0;
    probe(0, "a_async_reset", mk(8'h00, 2'd0, 0, 0, 2'b00));
    idle(1);
    rst_a = 1'b1;
    idle(2);

    expect_pt(0, "a_simultaneous", mk(8'h01, 2'd1, 1, 0, 2'b00));
    pulse(0, 2'b11, 0);
    idle(4);

    // Reset mid-hold with a level still high across release: counts once
    expect_pt(0, "a_pre_reset_point", mk(8'h02, 2'd1, 1, 0, 2'b00));
    pulse(0, 2'b01, 0);
    pt_a = 2'b01;
    idle(1);
    rst_a = 1'b0;
    probe(0, "a_reset_mid_hold", mk(8'h00, 2'd0, 0, 0, 2'b00));
    expect_pt(0, "a_level_after_reset", mk(8'h01, 2'd1, 1, 0, 2'b00));
    idle(1);
    rst_a = 1'b1;
    idle(10);
    pt_a = 2'b00;
    idle(3);
    probe(0, "a_level_counted_once", mk(8'h01, 2'd1, 0, 0, 2'b00));

    // new_game in POINT_HOLD with a concurrent point, then in PLAY with a point event
    expect_pt(0, "a_before_new_game", mk(8'h11, 2'd0, 1, 0, 2'b00));
    pulse(0, 2'b10, 0);
    pulse(0, 2'b01, 1);
    probe(0, "a_new_game_in_hold", mk(8'h00, 2'd0, 0, 0, 2'b00));
    idle(1);
    pulse(0, 2'b10, 1);
    probe(0, "a_new_game_beats_point", mk(8'h00, 2'd0, 0, 0, 2'b00));
    idle(6);
    probe(0, "a_idle_after_new_game", mk(8'h00, 2'd0, 0, 0, 2'b00));

    // Saturation instance: alternate to 14:14, then 15:14 wins on saturation
    for (int i = 1; i <= 14; i++) begin
      expect_pt(1, "b_rally_p0", mk({4'(i - 1), 4'(i)}, 2'd1, 1, 0, 2'b00));
      pulse(1, 2'b01, 0);
      idle(4);
      expect_pt(1, "b_rally_p1", mk({4'(i), 4'(i)}, 2'd0, 1, 0, 2'b00));
      pulse(1, 2'b10, 0);
      idle(4);
    end
    expect_pt(1, "b_saturation_win", mk(8'hEF, 2'd1, 1, 1, 2'b01));
    pulse(1, 2'b01, 0);
    idle(2);
    pulse(1, 2'b10, 0);
    pulse(1, 2'b01, 0);
    idle(6);
    probe(1, "b_no_change_after_win", mk(8'hEF, 2'd1, 1, 1, 2'b01));
    idle(1);
    ng_b = 1'b1;
    idle(1);
    ng_b = 1'b0;
    probe(1, "b_new_game_from_match_over", mk(8'h00, 2'd0, 0, 0, 2'b00));
    idle(2);

    fin_req = 1'b1;
    idle(3);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
